apb_master_arbiter: RTL and testbench

- Shares one APB slave-side bus between two APB masters: M0, the MIPS APB wrapper, and M1, a second bus master such as a DMA or debug port.
- Arbitrates round-robin and regenerates a clean SETUP/ACCESS sequence on the slave side for the granted master.
- Routes PREADY/PRDATA/PSLVERR back to the granted master only; the non-granted master is stalled in its ACCESS phase until served.
- Sits between the masters and the APB address decoder/slaves.

---
 rtl/apb_master_arbiter.sv | 128 ++++++++++++
 tb/tb_apb_master_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - two-master round-robin APB arbiter driving one slave-side APB bus
module apb_master_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                M0_PSEL,
    input  logic                M0_PENABLE,
    input  logic [ADDR_W-1:0]   M0_PADDR,
    input  logic                M0_PWRITE,
    input  logic [DATA_W-1:0]   M0_PWDATA,
    input  logic [DATA_W/8-1:0] M0_PSTRB,
    output logic                M0_PREADY,
    output logic [DATA_W-1:0]   M0_PRDATA,
    output logic                M0_PSLVERR,
    input  logic                M1_PSEL,
    input  logic                M1_PENABLE,
    input  logic [ADDR_W-1:0]   M1_PADDR,
    input  logic                M1_PWRITE,
    input  logic [DATA_W-1:0]   M1_PWDATA,
    input  logic [DATA_W/8-1:0] M1_PSTRB,
    output logic                M1_PREADY,
    output logic [DATA_W-1:0]   M1_PRDATA,
    output logic                M1_PSLVERR,
    output logic                PSEL,
    output logic                PENABLE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PWRITE,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic                PREADY,
    input  logic                PSLVERR,
    input  logic [DATA_W-1:0]   PRDATA,
    output logic                GNT,
    output logic                BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t state, state_nxt;
    logic   gnt, gnt_nxt;
    logic   last, last_nxt;

    // Master PENABLE carries no sequencing information; the slave phase is regenerated here.
    logic unused_penable;
    assign unused_penable = M0_PENABLE | M1_PENABLE;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= ST_IDLE;
            gnt   <= 1'b1;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        last_nxt   = last;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        PADDR      = '0;
        PWRITE     = 1'b0;
        PWDATA     = '0;
        PSTRB      = '0;
        M0_PREADY  = 1'b0;
        M0_PRDATA  = '0;
        M0_PSLVERR = 1'b0;
        M1_PREADY  = 1'b0;
        M1_PRDATA  = '0;
        M1_PSLVERR = 1'b0;

        case (state)
            ST_IDLE: begin
                if (M0_PSEL || M1_PSEL) begin
                    // On a tie the master that was not served last wins.
                    gnt_nxt   = (M0_PSEL && M1_PSEL) ? ~last : M1_PSEL;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (gnt) begin
                    M1_PREADY  = PREADY;
                    M1_PRDATA  = PRDATA;
                    M1_PSLVERR = PSLVERR;
                end else begin
                    M0_PREADY  = PREADY;
                    M0_PRDATA  = PRDATA;
                    M0_PSLVERR = PSLVERR;
                end
                if (PREADY) begin
                    last_nxt  = gnt;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // The stored grant drives the mux even if that master drops PSEL mid-transfer.
        if (state != ST_IDLE) begin
            PADDR  = gnt ? M1_PADDR  : M0_PADDR;
            PWRITE = gnt ? M1_PWRITE : M0_PWRITE;
            PWDATA = gnt ? M1_PWDATA : M0_PWDATA;
            PSTRB  = gnt ? M1_PSTRB  : M0_PSTRB;
        end
    end

    assign BUSY = (state != ST_IDLE);
    assign GNT  = gnt;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - directed and randomized checks of apb_master_arbiter against a transaction model
module tb_apb_master_arbiter;

    logic        PCLK;
    logic        PRESETn;
    logic        m_psel   [2];
    logic        m_pen    [2];
    logic [31:0] m_paddr  [2];
    logic        m_pwrite [2];
    logic [31:0] m_pwdata [2];
    logic [3:0]  m_pstrb  [2];
    logic        m0_pready, m1_pready, m0_pslverr, m1_pslverr;
    logic [31:0] m0_prdata, m1_prdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR, GNT, BUSY;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;

    int total = 0;
    int bad   = 0;
    int last_m;
    int late_added;
    int w;
    int pend [2];
    int seq [$];

    apb_master_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .M0_PSEL(m_psel[0]), .M0_PENABLE(m_pen[0]), .M0_PADDR(m_paddr[0]),
        .M0_PWRITE(m_pwrite[0]), .M0_PWDATA(m_pwdata[0]), .M0_PSTRB(m_pstrb[0]),
        .M0_PREADY(m0_pready), .M0_PRDATA(m0_prdata), .M0_PSLVERR(m0_pslverr),
        .M1_PSEL(m_psel[1]), .M1_PENABLE(m_pen[1]), .M1_PADDR(m_paddr[1]),
        .M1_PWRITE(m_pwrite[1]), .M1_PWDATA(m_pwdata[1]), .M1_PSTRB(m_pstrb[1]),
        .M1_PREADY(m1_pready), .M1_PRDATA(m1_prdata), .M1_PSLVERR(m1_pslverr),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .PRDATA(PRDATA), .GNT(GNT), .BUSY(BUSY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pready_of(input int x);
        return (x == 1) ? m1_pready : m0_pready;
    endfunction

    function automatic logic [31:0] prdata_of(input int x);
        return (x == 1) ? m1_prdata : m0_prdata;
    endfunction

    function automatic logic pslverr_of(input int x);
        return (x == 1) ? m1_pslverr : m0_pslverr;
    endfunction

    task automatic new_req(input int x);
        m_paddr[x]  = $urandom;
        m_pwdata[x] = $urandom;
        m_pwrite[x] = 1'($urandom_range(0, 1));
        m_pstrb[x]  = 4'($urandom_range(0, 15));
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        m_psel[0] = 1'b0;
        m_psel[1] = 1'b0;
        PREADY = 1'b0;
        PRDATA = '0;
        PSLVERR = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        last_m = 1;
    endtask

    task automatic check_slave_ctrl(input string tag, input int x);
        check({tag, "_gnt"},    GNT,    x);
        check({tag, "_paddr"},  PADDR,  m_paddr[x]);
        check({tag, "_pwrite"}, PWRITE, m_pwrite[x]);
        check({tag, "_pwdata"}, PWDATA, m_pwdata[x]);
        check({tag, "_pstrb"},  PSTRB,  m_pstrb[x]);
        check({tag, "_m0rdy"},  m0_pready, 0);
        check({tag, "_m1rdy"},  m1_pready, 0);
    endtask

    task automatic idle_cycle();
        @(negedge PCLK);
        check("idle_psel", PSEL, 0);
        check("idle_busy", BUSY, 0);
        check("idle_gnt_hold", GNT, last_m);
        @(posedge PCLK);
        #1;
    endtask

    // One full arbitration round from the IDLE cycle through completion.
    task automatic run_round(input int waits, input logic [31:0] rd, input logic err,
                             input bit late, input bit drop, output int win);
        int o;
        if (m_psel[0] && m_psel[1]) win = 1 - last_m;
        else                        win = m_psel[1] ? 1 : 0;
        o = 1 - win;
        @(negedge PCLK);
        check("idle_psel", PSEL, 0);
        check("idle_busy", BUSY, 0);
        check("idle_paddr", PADDR, 0);
        check("idle_m0rdy", m0_pready, 0);
        check("idle_m1rdy", m1_pready, 0);
        @(posedge PCLK);
        #1;
        @(negedge PCLK);
        check("setup_psel", PSEL, 1);
        check("setup_penable", PENABLE, 0);
        check("setup_busy", BUSY, 1);
        check_slave_ctrl("setup", win);
        for (int i = 0; i < waits; i++) begin
            @(posedge PCLK);
            #1 PREADY = 1'b0;
            if (i == 0 && late && !m_psel[o]) begin
                new_req(o);
                m_psel[o] = 1'b1;
                late_added = o;
            end
            if (i == 0 && drop) m_psel[win] = 1'b0;
            @(negedge PCLK);
            check("wait_psel", PSEL, 1);
            check("wait_penable", PENABLE, 1);
            check_slave_ctrl("wait", win);
        end
        @(posedge PCLK);
        #1;
        PREADY  = 1'b1;
        PRDATA  = rd;
        PSLVERR = err;
        @(negedge PCLK);
        check("acc_penable", PENABLE, 1);
        check("acc_gnt", GNT, win);
        check("acc_paddr", PADDR, m_paddr[win]);
        check("acc_rdy_win", pready_of(win), 1);
        check("acc_rdata_win", prdata_of(win), rd);
        check("acc_err_win", pslverr_of(win), err);
        check("acc_rdy_other", pready_of(o), 0);
        check("acc_rdata_other", prdata_of(o), 0);
        check("acc_err_other", pslverr_of(o), 0);
        @(posedge PCLK);
        #1;
        PREADY  = 1'b0;
        PRDATA  = '0;
        PSLVERR = 1'b0;
        last_m  = win;
    endtask

    initial begin
        PRESETn = 1'b0;
        PREADY = 1'b0;
        PRDATA = '0;
        PSLVERR = 1'b0;
        for (int x = 0; x < 2; x++) begin
            m_psel[x] = 1'b0;
            m_pen[x] = 1'b0;
            m_paddr[x] = '0;
            m_pwrite[x] = 1'b0;
            m_pwdata[x] = '0;
            m_pstrb[x] = '0;
        end
        late_added = -1;
        do_reset();

        // Reset state
        @(negedge PCLK);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_busy", BUSY, 0);
        check("rst_gnt", GNT, 1);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_m0rdy", m0_pready, 0);
        check("rst_m1rdy", m1_pready, 0);
        @(posedge PCLK);
        #1;

        // Single M0 write
        m_psel[0] = 1'b1;
        m_paddr[0] = 32'h4000_0010;
        m_pwdata[0] = 32'hDEAD_BEEF;
        m_pwrite[0] = 1'b1;
        m_pstrb[0] = 4'hF;
        run_round(0, 32'h0, 1'b0, 1'b0, 1'b0, w);
        m_psel[0] = 1'b0;
        idle_cycle();

        // Simultaneous reads after reset: M0 first, M1 stalled until its turn
        do_reset();
        m_psel[0] = 1'b1; m_paddr[0] = 32'h10; m_pwrite[0] = 1'b0;
        m_psel[1] = 1'b1; m_paddr[1] = 32'h20; m_pwrite[1] = 1'b0;
        run_round(0, 32'h11, 1'b0, 1'b0, 1'b0, w);
        check("sim_first", w, 0);
        m_psel[0] = 1'b0;
        run_round(0, 32'h22, 1'b0, 1'b0, 1'b0, w);
        check("sim_second", w, 1);
        m_psel[1] = 1'b0;

        // Wait states with a late M1 request held off by the grant lock
        new_req(0);
        m_psel[0] = 1'b1;
        late_added = -1;
        run_round(3, $urandom, 1'b0, 1'b1, 1'b0, w);
        m_psel[0] = 1'b0;
        check("late_req_seen", late_added, 1);
        run_round(1, $urandom, 1'b0, 1'b0, 1'b0, w);
        m_psel[1] = 1'b0;

        // Fairness with both masters issuing back-to-back transfers
        do_reset();
        pend[0] = 4;
        pend[1] = 4;
        new_req(0);
        new_req(1);
        m_psel[0] = 1'b1;
        m_psel[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_round($urandom_range(0, 2), $urandom, 1'b0, 1'b0, 1'b0, w);
            seq.push_back(w);
            pend[w]--;
            if (pend[w] > 0) new_req(w);
            else m_psel[w] = 1'b0;
        end
        for (int i = 0; i < 8; i++) check("fair_seq", seq[i], i % 2);

        // Error response to M1
        new_req(1);
        m_psel[1] = 1'b1;
        m_pwrite[1] = 1'b1;
        run_round(1, $urandom, 1'b1, 1'b0, 1'b0, w);
        m_psel[1] = 1'b0;

        // Reset while ACCESS is waiting on the slave
        do_reset();
        new_req(1);
        m_psel[1] = 1'b1;
        @(posedge PCLK);
        @(posedge PCLK);
        #1 PREADY = 1'b0;
        @(negedge PCLK);
        check("pre_rst_penable", PENABLE, 1);
        #1 PRESETn = 1'b0;
        #1;
        check("arst_psel", PSEL, 0);
        check("arst_penable", PENABLE, 0);
        check("arst_busy", BUSY, 0);
        check("arst_gnt", GNT, 1);
        check("arst_m1rdy", m1_pready, 0);
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        last_m = 1;
        run_round(0, $urandom, 1'b0, 1'b0, 1'b0, w);
        check("arst_regrant", w, 1);
        m_psel[1] = 1'b0;

        // Randomized traffic against the transaction model
        pend[0] = 0;
        pend[1] = 0;
        for (int it = 0; it < 80; it++) begin
            for (int x = 0; x < 2; x++) begin
                if (pend[x] == 0 && $urandom_range(0, 2) == 0) begin
                    pend[x] = $urandom_range(1, 3);
                    new_req(x);
                end
            end
            m_psel[0] = (pend[0] > 0);
            m_psel[1] = (pend[1] > 0);
            if (!m_psel[0] && !m_psel[1]) begin
                idle_cycle();
            end else begin
                late_added = -1;
                run_round($urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), w);
                if (late_added >= 0) pend[late_added] = 1;
                pend[w]--;
                if (pend[w] > 0) new_req(w);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
